// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM command-port arbiter.
//   arb_state_t         : arbiter FSM states
//   arb_src_t           : granted source (VDP port, aux port, refresh)
//   VRAM_LANE_BIT       : byte-address bit that selects the 16-bit word lane
//   REFRESH_PENDING_MAX : saturation value of the outstanding-refresh count
//   lane_wdm()          : byte-lane enable pair for a given lane select
package vram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_ACK
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_VDP,
        SRC_AUX,
        SRC_REF
    } arb_src_t;

    localparam int         VRAM_LANE_BIT       = 16;
    localparam logic [2:0] REFRESH_PENDING_MAX = 3'd7;

    // Lane 0 (low byte) is enabled as {1,0}... i.e. bit0 set when lane=0 is
    // masked off: mc_wdm = {~lane, lane}.
    function automatic logic [1:0] lane_wdm(input logic lane);
        lane_wdm = {~lane, lane};
    endfunction

endpackage

// File: rtl/vram_refresh_sched.sv
// Periodic refresh scheduler for the VRAM arbiter.
// An interval counter runs 0..REFRESH_INTERVAL-1 and wraps; every wrap adds one
// outstanding refresh (saturating at 7). Each completed refresh removes one.
// Ports:
//   clk, reset_n       : clock, synchronous active-low reset
//   refresh_done       : one-cycle pulse when the arbiter finishes a refresh
//   refresh_pending[2:0]: number of outstanding refreshes
//   refresh_urgent     : two or more refreshes outstanding
module vram_refresh_sched
    import vram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 842
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       refresh_done,
    output logic [2:0] refresh_pending,
    output logic       refresh_urgent
);

    localparam int               CNT_W    = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A wrap and a completed refresh in the same cycle cancel out, even when
    // the count is saturated.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            refresh_pending <= 3'd0;
        end else if (wrap && refresh_done) begin
            refresh_pending <= refresh_pending;
        end else if (wrap && (refresh_pending != REFRESH_PENDING_MAX)) begin
            refresh_pending <= refresh_pending + 3'd1;
        end else if (refresh_done && (refresh_pending != 3'd0)) begin
            refresh_pending <= refresh_pending - 3'd1;
        end
    end

    assign refresh_urgent = (refresh_pending >= 3'd2);

endmodule

// File: rtl/vram_arbiter.sv
// Arbiter for the single SDRAM memory-controller command port behind VDP VRAM.
// Sources: VDP port, auxiliary port (debug/DMA) and periodic refresh.
// Byte addresses are 17 bits; bit 16 picks the byte lane inside a 16-bit word.
//
// Build option: VRAM_ARB_AUX_EN -- when defined the aux port takes part in
// arbitration; otherwise aux_req is ignored and aux_ack/aux_dout are tied 0.
//
// Ports:
//   clk, reset_n                  : SDRAM-domain clock, synchronous active-low reset
//   vdp_req/we/addr/din, vdp_dout/ack : VDP access port
//   aux_req/we/addr/din, aux_dout/ack : auxiliary access port
//   mc_read/mc_write/mc_refresh   : one-cycle command pulses to the controller
//   mc_addr/mc_din/mc_wdm         : command address, replicated write data, lane mask
//   mc_dout, mc_busy              : controller read data and busy flag
//   refresh_pending               : outstanding refresh count
//   timeout_err                   : sticky, controller never went busy after a command
//
// Handshake: a port raises *_req (level) with we/addr/din valid and holds it
// until it sees *_ack high for one cycle; the arbiter latches the request at
// grant, so inputs may change afterwards. *_dout is valid while *_ack is high
// and holds until the next completed read. A req still high in the cycle after
// ack is taken as a new request.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W           = 21,
    parameter int REFRESH_INTERVAL = 842,
    parameter int BUSY_TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vdp_req,
    input  logic              vdp_we,
    input  logic [16:0]       vdp_addr,
    input  logic [7:0]        vdp_din,
    output logic [7:0]        vdp_dout,
    output logic              vdp_ack,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [16:0]       aux_addr,
    input  logic [7:0]        aux_din,
    output logic [7:0]        aux_dout,
    output logic              aux_ack,
    output logic              mc_read,
    output logic              mc_write,
    output logic              mc_refresh,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [15:0]       mc_din,
    output logic [1:0]        mc_wdm,
    input  logic [15:0]       mc_dout,
    input  logic              mc_busy,
    output logic [2:0]        refresh_pending,
    output logic              timeout_err
);

    localparam int               TMO_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    // FSM state is kept as a named signal so checkers can bind to it.
    arb_state_t state, state_next;

    arb_src_t   src, grant_src;
    logic       grant;
    logic       we_q, lane_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic       refresh_urgent, refresh_done;
    logic [7:0] vdp_dout_q;
    logic [7:0] rd_byte;

    logic        sel_we;
    logic [16:0] sel_addr;
    logic [7:0]  sel_din;

    vram_refresh_sched #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_sched (
        .clk            (clk),
        .reset_n        (reset_n),
        .refresh_done   (refresh_done),
        .refresh_pending(refresh_pending),
        .refresh_urgent (refresh_urgent)
    );

    // Grant decision, only meaningful in IDLE. An urgent refresh outranks the
    // VDP; a single pending refresh only outranks the aux port.
    always_comb begin
        grant     = 1'b0;
        grant_src = SRC_VDP;
        if (!mc_busy) begin
            if (refresh_urgent) begin
                grant     = 1'b1;
                grant_src = SRC_REF;
            end else if (vdp_req) begin
                grant     = 1'b1;
                grant_src = SRC_VDP;
            end else if (refresh_pending != 3'd0) begin
                grant     = 1'b1;
                grant_src = SRC_REF;
            end
`ifdef VRAM_ARB_AUX_EN
            else if (aux_req) begin
                grant     = 1'b1;
                grant_src = SRC_AUX;
            end
`endif
        end
    end

    // Request fields of the port being granted.
    always_comb begin
        sel_we   = vdp_we;
        sel_addr = vdp_addr;
        sel_din  = vdp_din;
`ifdef VRAM_ARB_AUX_EN
        if (grant_src == SRC_AUX) begin
            sel_we   = aux_we;
            sel_addr = aux_addr;
            sel_din  = aux_din;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (grant) state_next = ST_CMD;
            ST_CMD:       state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (mc_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = ST_ACK;
                end
            end
            ST_WAIT_DONE: if (!mc_busy) state_next = ST_ACK;
            ST_ACK:       state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    assign rd_byte = lane_q ? mc_dout[15:8] : mc_dout[7:0];

`ifdef VRAM_ARB_AUX_EN
    logic [7:0] aux_dout_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src         <= SRC_VDP;
            we_q        <= 1'b0;
            lane_q      <= 1'b0;
            mc_addr     <= '0;
            mc_din      <= '0;
            mc_wdm      <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
            vdp_dout_q  <= '0;
`ifdef VRAM_ARB_AUX_EN
            aux_dout_q  <= '0;
`endif
        end else begin
            if ((state == ST_IDLE) && grant) begin
                src <= grant_src;
                if (grant_src == SRC_REF) begin
                    we_q    <= 1'b0;
                    lane_q  <= 1'b0;
                    mc_addr <= '0;
                    mc_din  <= '0;
                    mc_wdm  <= '0;
                end else begin
                    we_q    <= sel_we;
                    lane_q  <= sel_addr[VRAM_LANE_BIT];
                    mc_addr <= ADDR_W'(sel_addr[15:0]);
                    mc_din  <= {sel_din, sel_din};
                    mc_wdm  <= lane_wdm(sel_addr[VRAM_LANE_BIT]);
                end
            end

            if (state == ST_CMD) begin
                tmo_cnt <= '0;
            end else if ((state == ST_WAIT_BUSY) && !mc_busy) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if ((state == ST_WAIT_BUSY) && !mc_busy && (tmo_cnt == TMO_LAST)) begin
                timeout_err <= 1'b1;
            end

            // Read data is captured on the busy-fall edge only; writes and
            // timed-out commands leave the port's dout untouched.
            if ((state == ST_WAIT_DONE) && !mc_busy && !we_q) begin
                if (src == SRC_VDP) begin
                    vdp_dout_q <= rd_byte;
                end
`ifdef VRAM_ARB_AUX_EN
                if (src == SRC_AUX) begin
                    aux_dout_q <= rd_byte;
                end
`endif
            end
        end
    end

    assign mc_read      = (state == ST_CMD) && (src != SRC_REF) && !we_q;
    assign mc_write     = (state == ST_CMD) && (src != SRC_REF) && we_q;
    assign mc_refresh   = (state == ST_CMD) && (src == SRC_REF);
    assign vdp_ack      = (state == ST_ACK) && (src == SRC_VDP);
    assign refresh_done = (state == ST_ACK) && (src == SRC_REF);
    assign vdp_dout     = vdp_dout_q;

`ifdef VRAM_ARB_AUX_EN
    assign aux_ack  = (state == ST_ACK) && (src == SRC_AUX);
    assign aux_dout = aux_dout_q;
`else
    logic aux_unused;
    assign aux_unused = ^{aux_req, aux_we, aux_addr, aux_din};
    assign aux_ack    = 1'b0;
    assign aux_dout   = 8'h00;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed steps from the test plan plus
// a randomized single-transaction phase, checked against a behavioural model
// of the arbitration rules and a busy/read-data model of the memory controller.
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam int RI = 842;
    localparam int BT = 15;
`ifdef VRAM_ARB_AUX_EN
    localparam bit AUX_EN = 1'b1;
`else
    localparam bit AUX_EN = 1'b0;
`endif
    localparam logic [1:0] K_READ  = 2'd0;
    localparam logic [1:0] K_WRITE = 2'd1;
    localparam logic [1:0] K_REF   = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic        vdp_req = 1'b0, vdp_we = 1'b0;
    logic [16:0] vdp_addr = '0;
    logic [7:0]  vdp_din = '0, vdp_dout;
    logic        vdp_ack;
    logic        aux_req = 1'b0, aux_we = 1'b0;
    logic [16:0] aux_addr = '0;
    logic [7:0]  aux_din = '0, aux_dout;
    logic        aux_ack;
    logic        mc_read, mc_write, mc_refresh;
    logic [20:0] mc_addr;
    logic [15:0] mc_din;
    logic [1:0]  mc_wdm;
    logic [15:0] mc_dout;
    logic        mc_busy;
    logic [2:0]  refresh_pending;
    logic        timeout_err;

    vram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .vdp_req(vdp_req), .vdp_we(vdp_we), .vdp_addr(vdp_addr), .vdp_din(vdp_din),
        .vdp_dout(vdp_dout), .vdp_ack(vdp_ack),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_din(aux_din),
        .aux_dout(aux_dout), .aux_ack(aux_ack),
        .mc_read(mc_read), .mc_write(mc_write), .mc_refresh(mc_refresh),
        .mc_addr(mc_addr), .mc_din(mc_din), .mc_wdm(mc_wdm),
        .mc_dout(mc_dout), .mc_busy(mc_busy),
        .refresh_pending(refresh_pending), .timeout_err(timeout_err)
    );

    // ---------------- memory-controller model ----------------
    int          busy_len   = 5;   // posedges busy stays high after a command
    bit          busy_force = 1'b0;
    int          busy_cnt   = 0;
    logic [15:0] mem_rdata  = '0;
    assign mc_busy = busy_force || (busy_cnt != 0);
    assign mc_dout = mem_rdata;

    // ---------------- observation logs / scoreboard ----------------
    logic [40:0] cmd_q[$];          // {kind, addr, din, wdm}
    logic [40:0] exp_q[$];
    logic [7:0]  vdp_ack_q[$];
    logic [7:0]  aux_ack_q[$];
    int          ack_order[$];      // 1 = vdp, 2 = aux
    int          multi_cmd = 0;
    logic [7:0]  mdl_dout[2];

    int n_checks = 0;
    int n_fail   = 0;

    initial forever begin
        @(negedge clk);
        if ((32'(mc_read) + 32'(mc_write) + 32'(mc_refresh)) > 1) multi_cmd++;
        if (mc_read || mc_write || mc_refresh) begin
            cmd_q.push_back({mc_refresh ? K_REF : (mc_write ? K_WRITE : K_READ),
                             mc_addr, mc_din, mc_wdm});
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        if (vdp_ack) begin vdp_ack_q.push_back(vdp_dout); ack_order.push_back(1); end
        if (aux_ack) begin aux_ack_q.push_back(aux_dout); ack_order.push_back(2); end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no end of test, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {vdp_dout, vdp_ack, aux_dout, aux_ack, mc_read, mc_write, mc_refresh,
                mc_addr, mc_din, mc_wdm, refresh_pending, timeout_err};
    endfunction

    function automatic logic [40:0] exp_cmd(input bit we, input logic [16:0] a, input logic [7:0] d);
        return {we ? K_WRITE : K_READ, 21'(a[15:0]), d, d, ~a[16], a[16]};
    endfunction

    task automatic clear_logs();
        cmd_q.delete(); exp_q.delete(); vdp_ack_q.delete(); aux_ack_q.delete(); ack_order.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; vdp_req = 1'b0; aux_req = 1'b0; busy_force = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        mdl_dout[0] = 8'h00; mdl_dout[1] = 8'h00;
        clear_logs();
    endtask

    // Drives one or both ports and waits (bounded) for the expected acks,
    // dropping each req in the ack cycle. scr scrambles port inputs right
    // after the grant edge to show they are latched.
    task automatic run(input bit v_en, input bit v_we, input logic [16:0] v_a, input logic [7:0] v_d,
                       input bit a_en, input bit a_we, input logic [16:0] a_a, input logic [7:0] a_d,
                       input bit scr, output int lat);
        bit v_wait, a_wait;
        int t;
        vdp_we = v_we; vdp_addr = v_a; vdp_din = v_d; vdp_req = v_en;
        aux_we = a_we; aux_addr = a_a; aux_din = a_d; aux_req = a_en;
        v_wait = v_en;
        a_wait = a_en && AUX_EN;
        t = 0;
        while ((v_wait || a_wait) && (t < 300)) begin
            @(negedge clk);
            t++;
            if (scr && (t == 1)) begin
                vdp_we = ~vdp_we; vdp_addr = 17'($urandom); vdp_din = 8'($urandom);
                aux_we = ~aux_we; aux_addr = 17'($urandom); aux_din = 8'($urandom);
            end
            if (vdp_ack) begin vdp_req = 1'b0; v_wait = 1'b0; end
            if (aux_ack) begin aux_req = 1'b0; a_wait = 1'b0; end
        end
        vdp_req = 1'b0;
        aux_req = 1'b0;
        lat = t;
        chk("ack_within_bound", 64'(t < 300), 64'd1);
        #1;
    endtask

    task automatic score(input string tag);
        logic [40:0] e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (cmd_q.size() == 0) begin
                chk({tag, "_cmd_missing"}, 64'(e), 64'h1_0000_0000_0000);
            end else begin
                o = cmd_q.pop_front();
                if (e[40:39] == K_REF) chk({tag, "_cmd_kind"}, 64'(o[40:39]), 64'(K_REF));
                else                   chk({tag, "_cmd"}, 64'(o), 64'(e));
            end
        end
        chk({tag, "_no_extra_cmd"}, 64'(cmd_q.size()), 64'd0);
    endtask

    task automatic expect_single(input int port, input bit we, input logic [16:0] a,
                                 input logic [7:0] d, input logic [15:0] rd,
                                 input int lat, input int lat_exp, input string tag);
        exp_q.push_back(exp_cmd(we, a, d));
        score(tag);
        if (!we) mdl_dout[port] = a[16] ? rd[15:8] : rd[7:0];
        chk({tag, "_vdp_acks"}, 64'(vdp_ack_q.size()), (port == 0) ? 64'd1 : 64'd0);
        chk({tag, "_aux_acks"}, 64'(aux_ack_q.size()), (port == 1) ? 64'd1 : 64'd0);
        if ((port == 0) && (vdp_ack_q.size() == 1)) chk({tag, "_dout_at_ack"}, 64'(vdp_ack_q[0]), 64'(mdl_dout[0]));
        if ((port == 1) && (aux_ack_q.size() == 1)) chk({tag, "_dout_at_ack"}, 64'(aux_ack_q[0]), 64'(mdl_dout[1]));
        chk({tag, "_vdp_dout"}, 64'(vdp_dout), 64'(mdl_dout[0]));
        chk({tag, "_aux_dout"}, 64'(aux_dout), 64'(mdl_dout[1]));
        chk({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat;
        int waited;

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        do_reset();

        // Single VDP read, busy 5 cycles, upper lane
        busy_len = 5; mem_rdata = 16'hAB12;
        run(1'b1, 1'b0, 17'h1_0123, 8'h00, 1'b0, 1'b0, '0, '0, 1'b1, lat);
        expect_single(0, 1'b0, 17'h1_0123, 8'h00, 16'hAB12, lat, 2 + 5, "vdp_read");
        chk("vdp_read_byte", 64'(vdp_dout), 64'hAB);
        repeat (2) @(negedge clk); clear_logs();

        // VDP write, lower lane; dout keeps the previous read byte
        busy_len = 3;
        run(1'b1, 1'b1, 17'h0_0040, 8'h5A, 1'b0, 1'b0, '0, '0, 1'b1, lat);
        expect_single(0, 1'b1, 17'h0_0040, 8'h5A, 16'h0000, lat, 2 + 3, "vdp_write");
        repeat (2) @(negedge clk); clear_logs();

        // Contention: VDP wins, aux follows at the next IDLE
        busy_len = 2; mem_rdata = 16'h3C4D;
        run(1'b1, 1'b0, 17'h0_0200, 8'h11, 1'b1, 1'b0, 17'h1_0300, 8'h22, 1'b0, lat);
        repeat (10) @(negedge clk); #1;
        exp_q.push_back(exp_cmd(1'b0, 17'h0_0200, 8'h11));
        if (AUX_EN) exp_q.push_back(exp_cmd(1'b0, 17'h1_0300, 8'h22));
        score("contend");
        chk("contend_n_acks", 64'(ack_order.size()), AUX_EN ? 64'd2 : 64'd1);
        if (ack_order.size() > 0) chk("contend_first_ack", 64'(ack_order[0]), 64'd1);
        if (ack_order.size() > 1) chk("contend_second_ack", 64'(ack_order[1]), 64'd2);
        chk("contend_vdp_dout", 64'(vdp_dout), 64'h4D);
        chk("contend_aux_dout", 64'(aux_dout), AUX_EN ? 64'h3C : 64'h00);
        mdl_dout[0] = 8'h4D; mdl_dout[1] = AUX_EN ? 8'h3C : 8'h00;
        clear_logs();

        // Busy never rises: timeout after BT clocks, port still acked
        chk("timeout_err_clear", 64'(timeout_err), 64'd0);
        busy_len = 0;
        run(1'b1, 1'b1, 17'h1_0005, 8'hC3, 1'b0, 1'b0, '0, '0, 1'b1, lat);
        expect_single(0, 1'b1, 17'h1_0005, 8'hC3, 16'h0000, lat, 2 + BT, "timeout");
        chk("timeout_err_set", 64'(timeout_err), 64'd1);
        repeat (3) @(negedge clk);
        chk("timeout_err_sticky", 64'(timeout_err), 64'd1);

        // Random single transactions on either port (no refresh yet due)
        do_reset();
        chk("timeout_err_cleared_by_reset", 64'(timeout_err), 64'd0);
        for (int i = 0; i < 30; i++) begin
            int          port;
            bit          we;
            logic [16:0] a;
            logic [7:0]  d;
            port      = AUX_EN ? int'($urandom_range(0, 1)) : 0;
            we        = 1'($urandom_range(0, 1));
            a         = 17'($urandom);
            d         = 8'($urandom);
            busy_len  = int'($urandom_range(2, 6));
            mem_rdata = 16'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            clear_logs();
            if (port == 0) run(1'b1, we, a, d, 1'b0, 1'b0, '0, '0, 1'b1, lat);
            else           run(1'b0, 1'b0, '0, '0, 1'b1, we, a, d, 1'b1, lat);
            expect_single(port, we, a, d, mem_rdata, lat, 2 + busy_len, $sformatf("rnd%0d", i));
        end

        // Refresh: two intervals with the controller busy, then a VDP read
        do_reset();
        busy_force = 1'b1;
        repeat (2 * RI + 16) @(negedge clk);
        chk("refresh_pending_two", 64'(refresh_pending), 64'((2 * RI + 16) / RI));
        busy_len = 3; mem_rdata = 16'h7788;
        busy_force = 1'b0;
        run(1'b1, 1'b0, 17'h0_0010, 8'h00, 1'b0, 1'b0, '0, '0, 1'b0, lat);
        exp_q.push_back({K_REF, 39'd0});
        exp_q.push_back(exp_cmd(1'b0, 17'h0_0010, 8'h00));
        score("refresh_first");
        chk("refresh_pending_one", 64'(refresh_pending), 64'd1);
        chk("refresh_vdp_dout", 64'(vdp_dout), 64'h88);
        repeat (20) @(negedge clk); #1;
        chk("refresh_second_issued", 64'(cmd_q.size()), 64'd1);
        if (cmd_q.size() > 0) chk("refresh_second_kind", 64'(cmd_q[0][40:39]), 64'(K_REF));
        chk("refresh_pending_zero", 64'(refresh_pending), 64'd0);

        // Reset during WAIT_DONE abandons the command, no ack
        do_reset();
        busy_len = 8; mem_rdata = 16'hFFFF;
        vdp_we = 1'b0; vdp_addr = 17'h1_0000; vdp_din = 8'h00; vdp_req = 1'b1;
        waited = 0;
        while ((cmd_q.size() == 0) && (waited < 20)) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_cmd_seen", 64'(cmd_q.size()), 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0; vdp_req = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid_outputs", all_outs(), 64'd0);
        reset_n = 1'b1;
        repeat (15) @(negedge clk); #1;
        chk("rst_mid_no_ack", 64'(vdp_ack_q.size()), 64'd0);
        chk("rst_mid_no_new_cmd", 64'(cmd_q.size()), 64'd1);
        chk("rst_mid_dout", 64'(vdp_dout), 64'd0);

        chk("single_cmd_pulses", 64'(multi_cmd), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
